// File: rtl/image_read_stream.sv
// Streams one BMP frame (bottom-up, BGR byte order) out of a byte-wide frame
// memory as RGB pixels in top-down raster order, with a valid/ready handshake
// on the pixel side and a one-cycle done pulse after the last pixel.
module image_read_stream #(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int BITS_FOR_INDEX = 10,
   parameter int sizeOfWidth    = 8,
   parameter int ADDR_W         = 21
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      start,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [sizeOfWidth-1:0]    mem_rdata,
   output logic [sizeOfWidth-1:0]    DATA_R0,
   output logic [sizeOfWidth-1:0]    DATA_G0,
   output logic [sizeOfWidth-1:0]    DATA_B0,
   output logic [BITS_FOR_INDEX-1:0] rowIndex,
   output logic [BITS_FOR_INDEX-1:0] colIndex,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic                      busy,
   output logic                      Read_Done
);

   typedef enum logic [2:0] {
      IDLE, RD_B, RD_G, RD_R, CAP_R, VALID, DONE
   } state_e;

   localparam logic [BITS_FOR_INDEX-1:0] LAST_COL   = BITS_FOR_INDEX'(WIDTH - 1);
   localparam logic [BITS_FOR_INDEX-1:0] LAST_ROW   = BITS_FOR_INDEX'(HEIGHT - 1);
   localparam logic [BITS_FOR_INDEX-1:0] ONE_IDX    = BITS_FOR_INDEX'(1);
   localparam logic [ADDR_W-1:0]         ROW_STRIDE = ADDR_W'(WIDTH * 3);
   localparam logic [ADDR_W-1:0]         PIX_STRIDE = ADDR_W'(3);
   localparam logic [ADDR_W-1:0]         BOT_ROW    = ADDR_W'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0]         OFS_G      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0]         OFS_R      = ADDR_W'(2);

   state_e                    state_q;
   logic [BITS_FOR_INDEX-1:0] row_q, col_q;
   logic [BITS_FOR_INDEX-1:0] row_d, col_d;
   logic [sizeOfWidth-1:0]    data_r_q, data_g_q, data_b_q;
   logic                      mem_rd_en_q;
   logic [ADDR_W-1:0]         mem_addr_q;
   logic [ADDR_W-1:0]         cur_base, nxt_base, first_base;
   logic                      is_last;

   // Byte address of the blue sample of pixel (r, c); rows are stored bottom-up.
   function automatic logic [ADDR_W-1:0] pix_base(input logic [BITS_FOR_INDEX-1:0] r,
                                                  input logic [BITS_FOR_INDEX-1:0] c);
      logic [ADDR_W-1:0] mem_row;
      mem_row = BOT_ROW - ADDR_W'(r);
      return mem_row * ROW_STRIDE + ADDR_W'(c) * PIX_STRIDE;
   endfunction

   // Raster advance to the following pixel and the base addresses the FSM loads.
   always_comb begin
      row_d   = row_q;
      col_d   = col_q + ONE_IDX;
      is_last = (row_q == LAST_ROW) && (col_q == LAST_COL);
      if (col_q == LAST_COL) begin
         col_d = '0;
         row_d = row_q + ONE_IDX;
      end
      cur_base   = pix_base(row_q, col_q);
      nxt_base   = pix_base(row_d, col_d);
      first_base = pix_base('0, '0);
   end

   // Frame FSM: issues three byte reads per pixel, captures them one cycle
   // later, then holds the pixel until the downstream handshake.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         data_r_q    <= '0;
         data_g_q    <= '0;
         data_b_q    <= '0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  row_q       <= '0;
                  col_q       <= '0;
                  mem_rd_en_q <= 1'b1;
                  mem_addr_q  <= first_base;
                  state_q     <= RD_B;
               end
            end
            RD_B: begin
               mem_rd_en_q <= 1'b1;
               mem_addr_q  <= cur_base + OFS_G;
               state_q     <= RD_G;
            end
            RD_G: begin
               data_b_q    <= mem_rdata;
               mem_rd_en_q <= 1'b1;
               mem_addr_q  <= cur_base + OFS_R;
               state_q     <= RD_R;
            end
            RD_R: begin
               data_g_q    <= mem_rdata;
               mem_rd_en_q <= 1'b0;
               state_q     <= CAP_R;
            end
            CAP_R: begin
               data_r_q <= mem_rdata;
               state_q  <= VALID;
            end
            VALID: begin
               if (pix_ready) begin
                  if (is_last) begin
                     state_q <= DONE;
                  end else begin
                     row_q       <= row_d;
                     col_q       <= col_d;
                     mem_rd_en_q <= 1'b1;
                     mem_addr_q  <= nxt_base;
                     state_q     <= RD_B;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               mem_rd_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = mem_addr_q;
   assign DATA_R0   = data_r_q;
   assign DATA_G0   = data_g_q;
   assign DATA_B0   = data_b_q;
   assign rowIndex  = row_q;
   assign colIndex  = col_q;
   assign pix_valid = (state_q == VALID);
   assign busy      = (state_q != IDLE);
   assign Read_Done = (state_q == DONE);

endmodule

// File: tb/tb_image_read_stream.sv
// Scoreboard bench for image_read_stream on a 4x2 frame where byte[a] = a.
module tb_image_read_stream;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int BI = 10;
   localparam int SW = 8;
   localparam int AW = 21;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          start = 1'b0;
   logic          pix_ready = 1'b0;
   logic [SW-1:0] mem_rdata = '0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [SW-1:0] DATA_R0, DATA_G0, DATA_B0;
   logic [BI-1:0] rowIndex, colIndex;
   logic          pix_valid, busy, Read_Done;

   image_read_stream #(
      .WIDTH(W), .HEIGHT(H), .BITS_FOR_INDEX(BI), .sizeOfWidth(SW), .ADDR_W(AW)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
      .rowIndex(rowIndex), .colIndex(colIndex),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .busy(busy), .Read_Done(Read_Done)
   );

   always #5 HCLK = ~HCLK;

   // Frame memory: one-cycle read latency, contents equal to the address.
   always @(posedge HCLK) if (mem_rd_en) mem_rdata <= SW'(mem_addr);

   typedef struct {
      int row; int col; int rv; int gv; int bv;
   } pix_t;

   pix_t exp_q[$];
   int   addr_q[$];
   int   checks = 0;
   int   failures = 0;
   int   done_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      checks++;
      failures++;
      $display("FAIL %s actual=%0d expected=none", name, act);
   endtask

   // Reference: every pixel of the frame in raster order, from the layout rule.
   task automatic push_frame();
      pix_t p;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int base;
            base = W * 3 * (H - 1 - r) + 3 * c;
            addr_q.push_back(base);
            addr_q.push_back(base + 1);
            addr_q.push_back(base + 2);
            p.row = r; p.col = c;
            p.bv = base % 256; p.gv = (base + 1) % 256; p.rv = (base + 2) % 256;
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
      chk({tag, "_addr"}, int'(mem_addr), 0);
      chk({tag, "_R"}, int'(DATA_R0), 0);
      chk({tag, "_G"}, int'(DATA_G0), 0);
      chk({tag, "_B"}, int'(DATA_B0), 0);
      chk({tag, "_row"}, int'(rowIndex), 0);
      chk({tag, "_col"}, int'(colIndex), 0);
      chk({tag, "_valid"}, int'(pix_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(Read_Done), 0);
   endtask

   // Monitor: pops expectations on reads and handshakes, checks hold stability.
   pix_t held;
   bit   hold_pend = 1'b0;
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         hold_pend = 1'b0;
      end else begin
         if (Read_Done) done_seen++;
         if (mem_rd_en) begin
            if (addr_q.size() == 0) unexpected("rd_addr_extra", int'(mem_addr));
            else chk("rd_addr", int'(mem_addr), addr_q.pop_front());
         end
         if (hold_pend) begin
            chk("hold_valid", int'(pix_valid), 1);
            chk("hold_row", int'(rowIndex), held.row);
            chk("hold_col", int'(colIndex), held.col);
            chk("hold_R", int'(DATA_R0), held.rv);
            chk("hold_G", int'(DATA_G0), held.gv);
            chk("hold_B", int'(DATA_B0), held.bv);
         end
         hold_pend = 1'b0;
         if (pix_valid) begin
            chk("rd_while_valid", int'(mem_rd_en), 0);
            if (pix_ready) begin
               if (exp_q.size() == 0) begin
                  unexpected("pix_extra", int'(colIndex));
               end else begin
                  pix_t p;
                  p = exp_q.pop_front();
                  chk("pix_row", int'(rowIndex), p.row);
                  chk("pix_col", int'(colIndex), p.col);
                  chk("pix_R", int'(DATA_R0), p.rv);
                  chk("pix_G", int'(DATA_G0), p.gv);
                  chk("pix_B", int'(DATA_B0), p.bv);
               end
            end else begin
               hold_pend = 1'b1;
               held.row = int'(rowIndex); held.col = int'(colIndex);
               held.rv = int'(DATA_R0); held.gv = int'(DATA_G0); held.bv = int'(DATA_B0);
            end
         end
      end
   end

   // Pulse start for one cycle; returns just after the edge that samples it.
   task automatic start_frame();
      start = 1'b1;
      @(posedge HCLK); #1;
      start = 1'b0;
   endtask

   // mode 0: ready high; 1: random ready with a 7-cycle stall at row0/col2;
   // 2: ready high with start poked mid-frame and during DONE.
   task automatic run_frame(input int mode, output int first_valid, output int n);
      int stall;
      stall = 0;
      first_valid = -1;
      n = 0;
      while (!Read_Done && n < 2000) begin
         if (mode == 1) begin
            if (pix_valid && rowIndex == 0 && colIndex == 2 && stall < 7) begin
               pix_ready = 1'b0;
               stall++;
            end else begin
               pix_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            pix_ready = 1'b1;
         end
         start = (mode == 2 && (n == 7 || n == 21)) ? 1'b1 : 1'b0;
         @(posedge HCLK); #1;
         n++;
         if (pix_valid && first_valid < 0) first_valid = n;
      end
      start = 1'b0;
      if (!Read_Done) unexpected("frame_timeout", n);
      if (mode == 1) chk("stall_cycles", stall, 7);
      if (mode == 2) begin
         start = 1'b1;
         @(posedge HCLK); #1;
         start = 1'b0;
      end
   endtask

   initial begin
      int fv, n;
      repeat (3) @(posedge HCLK);
      #1;
      check_zero("reset");
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      chk("idle_busy", int'(busy), 0);

      // Frame with ready held high: latency and total length.
      push_frame();
      start_frame();
      run_frame(0, fv, n);
      chk("first_valid_lat", fv, 4);
      chk("start_to_done", n, 40);
      @(posedge HCLK); #1;
      chk("busy_after", int'(busy), 0);
      chk("done_count1", done_seen, 1);

      // Random backpressure including a long stall.
      push_frame();
      start_frame();
      run_frame(1, fv, n);
      @(posedge HCLK); #1;
      chk("done_count2", done_seen, 2);

      // Start while busy and in DONE must not launch another frame.
      push_frame();
      start_frame();
      run_frame(2, fv, n);
      repeat (12) begin
         @(posedge HCLK); #1;
         chk("no_restart_busy", int'(busy), 0);
      end
      chk("done_count3", done_seen, 3);

      // Asynchronous reset in RD_G of row1/col1 (G address 4).
      push_frame();
      start_frame();
      pix_ready = 1'b1;
      n = 0;
      while (!(mem_rd_en && mem_addr == AW'(4)) && n < 200) begin
         @(posedge HCLK); #1;
         n++;
      end
      if (n >= 200) unexpected("reset_point_timeout", n);
      #2 HRESETn = 1'b0;
      #1;
      check_zero("async_rst");
      addr_q.delete();
      exp_q.delete();
      repeat (3) @(posedge HCLK);
      #1;
      check_zero("held_rst");
      HRESETn = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_no_done", done_seen, 3);
      chk("rst_wait_start", int'(busy), 0);

      // Fresh frame after reset starts again from row0/col0.
      push_frame();
      start_frame();
      run_frame(1, fv, n);
      @(posedge HCLK); #1;
      chk("done_count4", done_seen, 4);
      chk("pix_left", exp_q.size(), 0);
      chk("addr_left", addr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0t expected=finish", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/image_read_stream.md
IMAGE_READ_STREAM -- requirements
Module: image_read_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 768, image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 512, image height in pixels.
REQ-003 SHALL have parameter BITS_FOR_INDEX, default 10, width of the row and column indices.
REQ-004 SHALL have parameter sizeOfWidth, default 8, bits per colour channel.
REQ-005 SHALL have parameter ADDR_W, default 21, frame-memory byte address width, at least ceil(lg(WIDTH*HEIGHT*3)).
REQ-006 SHALL have port HCLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port HRESETn, input, 1 bit, reset; asynchronous and active-low.
REQ-008 SHALL have port start, input, 1 bit, one-cycle request to stream one frame.
REQ-009 SHALL have port mem_rd_en, output, 1 bit, frame-memory read strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits, byte address into the frame memory.
REQ-011 SHALL have port mem_rdata, input, sizeOfWidth bits, read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port DATA_R0, output, sizeOfWidth bits, red channel of the current pixel.
REQ-013 SHALL have port DATA_G0, output, sizeOfWidth bits, green channel.
REQ-014 SHALL have port DATA_B0, output, sizeOfWidth bits, blue channel.
REQ-015 SHALL have port rowIndex, output, BITS_FOR_INDEX bits, row of the current pixel, 0 = top.
REQ-016 SHALL have port colIndex, output, BITS_FOR_INDEX bits, column of the current pixel, 0 = left.
REQ-017 SHALL have port pix_valid, output, 1 bit, pixel outputs hold a valid pixel.
REQ-018 SHALL have port pix_ready, input, 1 bit, downstream accepts the pixel.
REQ-019 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-020 SHALL have port Read_Done, output, 1 bit, one-cycle pulse after the last pixel is accepted.

Function
REQ-021 Frame memory SHALL use BMP bottom-up BGR layout: base = WIDTH*3*(HEIGHT-1-row) + 3*col; B at base+0, G at base+1, R at base+2.
REQ-022 FSM states SHALL be IDLE, RD_B, RD_G, RD_R, CAP_R, VALID and DONE.
REQ-023 In IDLE with start=1, the block SHALL clear row and col to 0 and enter RD_B.
REQ-024 In IDLE with start=0, and in any other state, start SHALL be ignored.
REQ-025 In RD_B the block SHALL assert mem_rd_en with the B address, then go to RD_G.
REQ-026 In RD_G the block SHALL assert mem_rd_en with the G address, capture mem_rdata as B, then go to RD_R.
REQ-027 In RD_R the block SHALL assert mem_rd_en with the R address, capture mem_rdata as G, then go to CAP_R.
REQ-028 In CAP_R the block SHALL capture mem_rdata as R, then go to VALID.
REQ-029 mem_rd_en SHALL be 0 outside RD_B, RD_G and RD_R.
REQ-030 pix_valid SHALL be 1 exactly while in VALID.
REQ-031 While pix_valid=1, DATA_*, rowIndex and colIndex SHALL stay stable until the cycle in which pix_ready=1 (handshake).
REQ-032 On a handshake that is not the last pixel, col SHALL increment; at col=WIDTH-1, col SHALL wrap to 0 and row SHALL increment; next state SHALL be RD_B.
REQ-033 On a handshake at row=HEIGHT-1, col=WIDTH-1, next state SHALL be DONE.
REQ-034 In DONE, Read_Done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-035 Read_Done SHALL be 0 in every other state.
REQ-036 Latency SHALL be: first pix_valid high 4 cycles after the edge that samples start; minimum 5 cycles per pixel with pix_ready held high.
REQ-037 All address arithmetic SHALL be unsigned at ADDR_W bits with no truncation for the parameter ranges.

Reset
REQ-038 While HRESETn=0, regardless of clock, the state SHALL be IDLE.
REQ-039 While HRESETn=0, every output SHALL be 0: mem_rd_en, mem_addr, DATA_R0/G0/B0, rowIndex, colIndex, pix_valid, busy and Read_Done.
REQ-040 Reset asserted mid-frame SHALL abort the frame with no Read_Done pulse.
REQ-041 After reset is released, the block SHALL wait for a new start.

Verification (bench parameters WIDTH=4, HEIGHT=2, memory byte[a]=a)
REQ-042 Scenario: start pulse, pix_ready=1 -> first handshake has row0/col0, addresses 12,13,14 read, B=12, G=13, R=14, pix_valid rises 4 cycles after start.
REQ-043 Scenario: full frame, pix_ready=1 -> 8 pixels in raster order; last pixel row1/col3 with B=9, G=10, R=11; one Read_Done pulse; 40 cycles start-to-Read_Done; busy low afterwards.
REQ-044 Scenario: pix_ready low for 7 cycles at pixel row0/col2 -> outputs stable (B=18, G=19, R=20), no memory reads, then advance to col3.
REQ-045 Scenario: start pulsed while busy and in DONE -> no restart, no second frame.
REQ-046 Scenario: HRESETn low during RD_G of pixel row1/col1 -> all outputs 0 immediately (asynchronous), no Read_Done; a new start then streams from row0/col0.
